// File: rtl/cb_rmw_sequencer.sv
// CB-prefix read-modify-write sequencer: drives the shared ALU for register or (HL) operands.
// Define SEQ_TIMEOUT_EN to abort memory waits after MEM_TIMEOUT unacked cycles.
module cb_rmw_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int ADDR_W      = 16
) (
    input  logic              clk4_2,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [4:0]        cmd_op,
    input  logic [2:0]        cmd_bit,
    input  logic              cmd_mem,
    input  logic [2:0]        cmd_reg,
    input  logic [7:0]        reg_rd_data,
    input  logic [ADDR_W-1:0] hl_addr,
    output logic [7:0]        operand_q,
    output logic [4:0]        alu_cntl,
    output logic [2:0]        alu_bit,
    output logic              alu_out_wr,
    input  logic [7:0]        alu_result,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_req,
    input  logic              mem_rd_ack,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_req,
    output logic [7:0]        mem_wr_data,
    input  logic              mem_wr_ack,
    output logic              reg_wr,
    output logic [2:0]        reg_wr_sel,
    output logic [7:0]        reg_wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam logic [4:0] OP_BIT  = 5'b01000;
    localparam logic [4:0] OP_RL   = 5'b01001;
    localparam logic [4:0] OP_SWAP = 5'b01101;
    localparam logic [4:0] OP_RES  = 5'b01111;

    typedef enum logic [2:0] {S_IDLE, S_MEM_RD, S_EXEC, S_WB, S_ERR} state_t;

    state_t              state_q;
    logic [4:0]          op_q;
    logic [2:0]          bit_q;
    logic [2:0]          reg_q;
    logic                mem_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          wdata_q;
    logic                wb_first_q;
    logic                rd_req_q;
    logic                wr_req_q;
    logic                alu_wr_q;
    logic                reg_wr_q;
    logic                done_q;
    logic                err_q;

`ifdef SEQ_TIMEOUT_EN
    localparam logic [3:0] WAIT_LAST = 4'(MEM_TIMEOUT - 1);
    logic [3:0]          wait_q;
`else
    if (MEM_TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

    function automatic logic op_supported(input logic [4:0] op);
        return (op == OP_BIT) || (op == OP_RL) || (op == OP_SWAP) || (op == OP_RES);
    endfunction

    always_ff @(posedge clk4_2 or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            bit_q      <= '0;
            reg_q      <= '0;
            mem_q      <= 1'b0;
            addr_q     <= '0;
            operand_q  <= '0;
            wdata_q    <= '0;
            wb_first_q <= 1'b0;
            rd_req_q   <= 1'b0;
            wr_req_q   <= 1'b0;
            alu_wr_q   <= 1'b0;
            reg_wr_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            wait_q     <= '0;
`endif
        end else begin
            alu_wr_q   <= 1'b0;
            reg_wr_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wb_first_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q   <= cmd_op;
                        bit_q  <= cmd_bit;
                        mem_q  <= cmd_mem;
                        reg_q  <= cmd_reg;
                        addr_q <= hl_addr;
                        if (!cmd_mem) operand_q <= reg_rd_data;
                        if (!op_supported(cmd_op)) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end else if (cmd_mem) begin
                            state_q  <= S_MEM_RD;
                            rd_req_q <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
                            wait_q   <= '0;
`endif
                        end else begin
                            state_q  <= S_EXEC;
                            alu_wr_q <= 1'b1;
                        end
                    end
                end
                S_MEM_RD: begin
                    if (mem_rd_ack) begin
                        operand_q <= mem_rd_data;
                        rd_req_q  <= 1'b0;
                        alu_wr_q  <= 1'b1;
                        state_q   <= S_EXEC;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (wait_q == WAIT_LAST) begin
                        rd_req_q <= 1'b0;
                        err_q    <= 1'b1;
                        state_q  <= S_ERR;
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
`endif
                end
                S_EXEC: begin
                    // ALU result appears on alu_result during the first WB cycle.
                    state_q    <= S_WB;
                    wb_first_q <= 1'b1;
                    if (op_q == OP_BIT) begin
                        done_q <= 1'b1;
                    end else if (!mem_q) begin
                        reg_wr_q <= 1'b1;
                        done_q   <= 1'b1;
                    end else begin
                        wr_req_q <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
                        wait_q   <= '0;
`endif
                    end
                end
                S_WB: begin
                    if (wb_first_q) wdata_q <= alu_result;
                    if (!wr_req_q) begin
                        state_q <= S_IDLE;
                    end else if (mem_wr_ack) begin
                        wr_req_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (wait_q == WAIT_LAST) begin
                        wr_req_q <= 1'b0;
                        err_q    <= 1'b1;
                        state_q  <= S_ERR;
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
`endif
                end
                S_ERR:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign alu_cntl    = op_q;
    assign alu_bit     = bit_q;
    assign alu_out_wr  = alu_wr_q;
    assign mem_addr    = addr_q;
    assign mem_rd_req  = rd_req_q;
    assign mem_wr_req  = wr_req_q;
    // Zero-wait writes complete in the capture cycle, so pass alu_result straight through then.
    assign mem_wr_data = !wr_req_q ? 8'h00 : (wb_first_q ? alu_result : wdata_q);
    assign reg_wr      = reg_wr_q;
    assign reg_wr_sel  = reg_q;
    assign reg_wr_data = reg_wr_q ? alu_result : 8'h00;
    assign done        = done_q | (wr_req_q & mem_wr_ack);
    assign err         = err_q;
endmodule

// File: tb/tb_cb_rmw_sequencer.sv
// Bench for cb_rmw_sequencer: transaction-level model sets per-cycle expectations, one
// negedge process compares them; hand-computed literals pin key results.
module tb_cb_rmw_sequencer;
    localparam int ADDR_W = 16;
    localparam logic [4:0] OP_BIT  = 5'b01000;
    localparam logic [4:0] OP_RL   = 5'b01001;
    localparam logic [4:0] OP_SWAP = 5'b01101;
    localparam logic [4:0] OP_RES  = 5'b01111;
`ifdef SEQ_TIMEOUT_EN
    localparam int TO = 15;
`else
    localparam int TO = 1000000;
`endif

    logic              clk4_2 = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0, cmd_ready;
    logic [4:0]        cmd_op = '0;
    logic [2:0]        cmd_bit = '0, cmd_reg = '0;
    logic              cmd_mem = 1'b0;
    logic [7:0]        reg_rd_data = '0;
    logic [ADDR_W-1:0] hl_addr = '0, mem_addr;
    logic [7:0]        operand_q, alu_result = '0, mem_rd_data = '0, mem_wr_data;
    logic [4:0]        alu_cntl;
    logic [2:0]        alu_bit, reg_wr_sel;
    logic              alu_out_wr, mem_rd_req, mem_rd_ack = 1'b0, mem_wr_req, mem_wr_ack = 1'b0;
    logic              reg_wr, busy, done, err;
    logic [7:0]        reg_wr_data;

    always #5 clk4_2 = ~clk4_2;

    cb_rmw_sequencer #(.MEM_TIMEOUT(15), .ADDR_W(ADDR_W)) dut (
        .clk4_2(clk4_2), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_bit(cmd_bit), .cmd_mem(cmd_mem), .cmd_reg(cmd_reg),
        .reg_rd_data(reg_rd_data), .hl_addr(hl_addr), .operand_q(operand_q),
        .alu_cntl(alu_cntl), .alu_bit(alu_bit), .alu_out_wr(alu_out_wr), .alu_result(alu_result),
        .mem_addr(mem_addr), .mem_rd_req(mem_rd_req), .mem_rd_ack(mem_rd_ack),
        .mem_rd_data(mem_rd_data), .mem_wr_req(mem_wr_req), .mem_wr_data(mem_wr_data),
        .mem_wr_ack(mem_wr_ack), .reg_wr(reg_wr), .reg_wr_sel(reg_wr_sel),
        .reg_wr_data(reg_wr_data), .busy(busy), .done(done), .err(err)
    );

    function automatic logic [7:0] alu_f(input logic [4:0] op, input logic [2:0] b, input logic [7:0] o);
        case (op)
            OP_RL:   return {o[6:0], o[7]};
            OP_SWAP: return {o[3:0], o[7:4]};
            OP_RES:  return o & ~(8'h01 << b);
            default: return o;
        endcase
    endfunction

    // Stand-in ALU: registered result, scrambled whenever not strobed.
    always @(posedge clk4_2) alu_result <= alu_out_wr ? alu_f(alu_cntl, alu_bit, operand_q) : 8'($urandom);

    int cyc = 0;
    always @(posedge clk4_2) cyc <= cyc + 1;

    int checks = 0, failures = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    logic              cmp_en = 1'b0;
    logic              exp_ready, exp_busy, exp_alu, exp_rd, exp_wr, exp_regwr, exp_done, exp_err;
    logic [4:0]        exp_op;
    logic [2:0]        exp_bit, exp_sel;
    logic [7:0]        exp_operand, exp_wdata, exp_rdata;
    logic [ADDR_W-1:0] exp_addr;

    int          n_alu = 0, n_regwr = 0, n_wrreq = 0, n_done = 0, n_err = 0;
    int          last_done_cyc = -1, last_err_cyc = -1, acc = 0;
    logic [7:0]  last_reg_data = '0, last_wdata = '0, last_operand = '0;
    logic [15:0] last_waddr = '0;

    always @(negedge clk4_2) begin
        if (cmp_en) begin
            chk("cmd_ready", cmd_ready, exp_ready);
            chk("busy", busy, exp_busy);
            chk("alu_out_wr", alu_out_wr, exp_alu);
            chk("mem_rd_req", mem_rd_req, exp_rd);
            chk("mem_wr_req", mem_wr_req, exp_wr);
            chk("reg_wr", reg_wr, exp_regwr);
            chk("done", done, exp_done);
            chk("err", err, exp_err);
            if (exp_alu) begin
                chk("alu_cntl", alu_cntl, exp_op);
                chk("alu_bit", alu_bit, exp_bit);
                chk("operand_q", operand_q, exp_operand);
            end
            if (exp_rd || exp_wr) chk("mem_addr", mem_addr, exp_addr);
            if (exp_wr) chk("mem_wr_data", mem_wr_data, exp_wdata);
            if (exp_regwr) begin
                chk("reg_wr_sel", reg_wr_sel, exp_sel);
                chk("reg_wr_data", reg_wr_data, exp_rdata);
            end
        end
        if (alu_out_wr) begin n_alu++; last_operand = operand_q; end
        if (reg_wr) begin n_regwr++; last_reg_data = reg_wr_data; end
        if (mem_wr_req) begin n_wrreq++; last_wdata = mem_wr_data; last_waddr = mem_addr; end
        if (done) begin n_done++; last_done_cyc = cyc; end
        if (err) begin n_err++; last_err_cyc = cyc; end
    end

    task automatic set_idle();
        exp_ready = 1'b1; exp_busy = 1'b0; exp_alu = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0;
        exp_regwr = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    endtask

    task automatic set_busy();
        set_idle();
        exp_ready = 1'b0;
        exp_busy  = 1'b1;
    endtask

    // Advance one cycle and fill every input with noise; callers override what matters.
    task automatic next_cycle();
        @(posedge clk4_2);
        #1;
        cmd_valid   = 1'($urandom);
        cmd_op      = 5'($urandom);
        cmd_bit     = 3'($urandom);
        cmd_mem     = 1'($urandom);
        cmd_reg     = 3'($urandom);
        reg_rd_data = 8'($urandom);
        hl_addr     = 16'($urandom);
        mem_rd_ack  = 1'($urandom);
        mem_wr_ack  = 1'($urandom);
        mem_rd_data = 8'($urandom);
    endtask

    task automatic idle_cycle();
        next_cycle();
        cmd_valid = 1'b0;
        set_idle();
    endtask

    task automatic run_cmd(input logic [4:0] op, input logic [2:0] b, input logic mem,
                           input logic [2:0] rg, input logic [7:0] rdata, input logic [15:0] hl,
                           input int rdw, input int wrw, input logic [7:0] mdata);
        logic [7:0] o, res;
        next_cycle();
        cmd_valid = 1'b1; cmd_op = op; cmd_bit = b; cmd_mem = mem; cmd_reg = rg;
        reg_rd_data = rdata; hl_addr = hl;
        set_idle();
        acc = cyc;
        o = mem ? mdata : rdata;
        if (!(op == OP_BIT || op == OP_RL || op == OP_SWAP || op == OP_RES)) begin
            next_cycle(); set_busy(); exp_err = 1'b1;
            return;
        end
        if (mem) begin
            for (int i = 0; i <= rdw && i < TO; i++) begin
                next_cycle(); set_busy(); exp_rd = 1'b1; exp_addr = hl;
                mem_rd_ack = (i == rdw);
                if (i == rdw) mem_rd_data = mdata;
            end
            if (rdw >= TO) begin
                next_cycle(); set_busy(); exp_err = 1'b1;
                return;
            end
        end
        next_cycle(); set_busy();
        exp_alu = 1'b1; exp_op = op; exp_bit = b; exp_operand = o;
        res = alu_f(op, b, o);
        if (op == OP_BIT) begin
            next_cycle(); set_busy(); exp_done = 1'b1;
        end else if (!mem) begin
            next_cycle(); set_busy();
            exp_regwr = 1'b1; exp_sel = rg; exp_rdata = res; exp_done = 1'b1;
        end else begin
            for (int j = 0; j <= wrw && j < TO; j++) begin
                next_cycle(); set_busy();
                exp_wr = 1'b1; exp_addr = hl; exp_wdata = res;
                mem_wr_ack = (j == wrw);
                exp_done = (j == wrw);
            end
            if (wrw >= TO) begin
                next_cycle(); set_busy(); exp_err = 1'b1;
            end
        end
    endtask

    initial begin
        int a0, r0, w0, d0, e0;
        logic [4:0] rop;
        set_idle();
        repeat (3) @(posedge clk4_2);
        @(negedge clk4_2);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_alu_out_wr", alu_out_wr, 0);
        chk("rst_alu_cntl", alu_cntl, 0);
        chk("rst_alu_bit", alu_bit, 0);
        chk("rst_operand_q", operand_q, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_rd_req", mem_rd_req, 0);
        chk("rst_mem_wr_req", mem_wr_req, 0);
        chk("rst_mem_wr_data", mem_wr_data, 0);
        chk("rst_reg_wr", reg_wr, 0);
        chk("rst_reg_wr_sel", reg_wr_sel, 0);
        chk("rst_reg_wr_data", reg_wr_data, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(posedge clk4_2); #1;
        reset = 1'b0;
        cmp_en = 1'b1;
        idle_cycle();

        // Register SWAP of A5 to r3
        run_cmd(OP_SWAP, 3'd0, 1'b0, 3'd3, 8'hA5, 16'h0000, 0, 0, 8'h00);
        idle_cycle();
        chk("t1_reg_data", last_reg_data, 8'h5A);
        chk("t1_latency", last_done_cyc - acc, 2);

        // (HL) RES 7: accept, 3 MEM_RD cycles (ack on the third), EXEC, 2 WB cycles
        run_cmd(OP_RES, 3'd7, 1'b1, 3'd0, 8'h00, 16'hC000, 2, 1, 8'hFF);
        idle_cycle();
        chk("t2_operand", last_operand, 8'hFF);
        chk("t2_wdata", last_wdata, 8'h7F);
        chk("t2_waddr", last_waddr, 16'hC000);
        chk("t2_latency", last_done_cyc - acc, 6);

        a0 = n_alu; r0 = n_regwr; w0 = n_wrreq;
        run_cmd(OP_BIT, 3'd3, 1'b0, 3'd2, 8'h08, 16'h0000, 0, 0, 8'h00);
        idle_cycle();
        chk("t3_alu_pulses", n_alu - a0, 1);
        chk("t3_no_reg_wr", n_regwr - r0, 0);
        chk("t3_no_mem_wr", n_wrreq - w0, 0);
        chk("t3_latency", last_done_cyc - acc, 2);

        a0 = n_alu; d0 = n_done;
        run_cmd(5'b00000, 3'd0, 1'b0, 3'd1, 8'h11, 16'h0000, 0, 0, 8'h00);
        idle_cycle();
        chk("t4_no_alu", n_alu - a0, 0);
        chk("t4_no_done", n_done - d0, 0);
        chk("t4_err_cycle", last_err_cyc - acc, 1);

        // Reset while the read request is outstanding
        d0 = n_done; e0 = n_err;
        next_cycle();
        cmd_valid = 1'b1; cmd_op = OP_RL; cmd_mem = 1'b1; hl_addr = 16'h1234; set_idle();
        next_cycle(); mem_rd_ack = 1'b0; set_busy(); exp_rd = 1'b1; exp_addr = 16'h1234;
        next_cycle(); mem_rd_ack = 1'b0; reset = 1'b1; cmd_valid = 1'b0; set_idle();
        @(negedge clk4_2); #1;
        chk("t5_mem_rd_req", mem_rd_req, 0);
        chk("t5_cmd_ready", cmd_ready, 1);
        chk("t5_mem_addr", mem_addr, 0);
        next_cycle(); reset = 1'b0; cmd_valid = 1'b0; set_idle();
        idle_cycle();
        chk("t5_no_done", n_done - d0, 0);
        chk("t5_no_err", n_err - e0, 0);

`ifdef SEQ_TIMEOUT_EN
        a0 = n_alu;
        run_cmd(OP_RL, 3'd0, 1'b1, 3'd0, 8'h00, 16'h8000, 40, 0, 8'h00);
        idle_cycle();
        chk("t6_no_alu", n_alu - a0, 0);
        chk("t6_err_cycle", last_err_cyc - acc, 16);
`endif

        for (int k = 0; k < 150; k++) begin
            case ($urandom_range(0, 4))
                0: rop = OP_BIT;
                1: rop = OP_RL;
                2: rop = OP_SWAP;
                3: rop = OP_RES;
                default: rop = 5'($urandom);
            endcase
            run_cmd(rop, 3'($urandom), 1'($urandom), 3'($urandom), 8'($urandom), 16'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), 8'($urandom));
            repeat ($urandom_range(0, 2)) idle_cycle();
        end
        idle_cycle();
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
